// File: rtl/e203_exu_bjp_pipe.sv
// ---------------------------------------------------------------------------
// e203_exu_bjp_pipe
//
// Branch/jump resolution unit with a single-entry output register stage.
// A request is resolved combinationally. The result is captured on the edge
// that accepts it and presented one cycle later. The stage stays full until
// the consumer takes it. A new request may be accepted on the same edge that
// the held result leaves, so back-to-back traffic has no bubble.
//
// Optional feature macro: E203_BJP_MISPRED_CNT_EN
//   defined   : saturating misprediction counter, counts result handshakes
//               with bjp_o_mispred = 1; bjp_cnt_clr clears it (clear wins).
//   undefined : no counter; bjp_mispred_cnt reads 0, bjp_cnt_clr ignored.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   bjp_i_valid/ready    request handshake
//   bjp_i_rs1/rs2        compare operands (JALR base in rs1)
//   bjp_i_imm, bjp_i_pc  sign-extended offset, instruction PC
//   bjp_i_op             0 BEQ 1 BNE 2 BLT 3 BGE 4 BLTU 5 BGEU 6 JAL 7 JALR
//   bjp_i_rv32           1 = 4-byte instruction, 0 = 2-byte
//   bjp_i_bprdt          predicted taken
//   bjp_o_valid/ready    result handshake
//   bjp_o_wbck_wdat/en   link address and write-back enable (jumps only)
//   bjp_o_tgt_pc         resolved next PC
//   bjp_o_cmt_prdt/rslv  predicted / resolved taken
//   bjp_o_mispred        prediction differs from resolution
//   bjp_cnt_clr          synchronous clear of the misprediction counter
//   bjp_mispred_cnt      misprediction count
// ---------------------------------------------------------------------------
module e203_exu_bjp_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bjp_i_valid,
  output logic             bjp_i_ready,
  input  logic [XLEN-1:0]  bjp_i_rs1,
  input  logic [XLEN-1:0]  bjp_i_rs2,
  input  logic [XLEN-1:0]  bjp_i_imm,
  input  logic [XLEN-1:0]  bjp_i_pc,
  input  logic [2:0]       bjp_i_op,
  input  logic             bjp_i_rv32,
  input  logic             bjp_i_bprdt,
  output logic             bjp_o_valid,
  input  logic             bjp_o_ready,
  output logic [XLEN-1:0]  bjp_o_wbck_wdat,
  output logic             bjp_o_wbck_en,
  output logic [XLEN-1:0]  bjp_o_tgt_pc,
  output logic             bjp_o_cmt_prdt,
  output logic             bjp_o_cmt_rslv,
  output logic             bjp_o_mispred,
  input  logic             bjp_cnt_clr,
  output logic [CNT_W-1:0] bjp_mispred_cnt
);

  localparam logic [2:0] OP_BEQ  = 3'd0;
  localparam logic [2:0] OP_BNE  = 3'd1;
  localparam logic [2:0] OP_BLT  = 3'd2;
  localparam logic [2:0] OP_BGE  = 3'd3;
  localparam logic [2:0] OP_BLTU = 3'd4;
  localparam logic [2:0] OP_BGEU = 3'd5;
  localparam logic [2:0] OP_JAL  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  // Mask that clears bit 0 of the JALR target.
  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  logic            accept_s;
  logic            handshake_s;
  logic            eq_s;
  logic            lt_s;
  logic            ltu_s;
  logic            rslv_s;
  logic            jump_s;
  logic [XLEN-1:0] seq_pc_s;
  logic [XLEN-1:0] br_tgt_s;
  logic [XLEN-1:0] jalr_sum_s;
  logic [XLEN-1:0] tgt_s;
  logic [XLEN-1:0] wdat_s;

  logic            o_valid_r;
  logic [XLEN-1:0] wdat_r;
  logic            wbck_en_r;
  logic [XLEN-1:0] tgt_r;
  logic            prdt_r;
  logic            rslv_r;
  logic            mispred_r;

  // The stage can take a request when empty or when its entry leaves now.
  assign bjp_i_ready = ~o_valid_r | bjp_o_ready;
  assign accept_s    = bjp_i_valid & bjp_i_ready;
  assign handshake_s = o_valid_r & bjp_o_ready;

  // Resolve the request: compare, pick the next PC, form the link address.
  always_comb begin
    eq_s       = (bjp_i_rs1 == bjp_i_rs2);
    lt_s       = ($signed(bjp_i_rs1) < $signed(bjp_i_rs2));
    ltu_s      = (bjp_i_rs1 < bjp_i_rs2);
    // All sums wrap modulo 2^XLEN; the carry out is intentionally dropped.
    seq_pc_s   = bjp_i_pc + (bjp_i_rv32 ? XLEN'(3'd4) : XLEN'(3'd2));
    br_tgt_s   = bjp_i_pc + bjp_i_imm;
    jalr_sum_s = bjp_i_rs1 + bjp_i_imm;
    rslv_s     = 1'b0;
    jump_s     = 1'b0;
    case (bjp_i_op)
      OP_BEQ:  rslv_s = eq_s;
      OP_BNE:  rslv_s = ~eq_s;
      OP_BLT:  rslv_s = lt_s;
      OP_BGE:  rslv_s = ~lt_s;
      OP_BLTU: rslv_s = ltu_s;
      OP_BGEU: rslv_s = ~ltu_s;
      OP_JAL: begin
        rslv_s = 1'b1;
        jump_s = 1'b1;
      end
      OP_JALR: begin
        rslv_s = 1'b1;
        jump_s = 1'b1;
      end
      default: begin
        rslv_s = 1'b0;
        jump_s = 1'b0;
      end
    endcase
    if (bjp_i_op == OP_JALR) begin
      tgt_s = jalr_sum_s & JALR_MASK;
    end else if (rslv_s) begin
      tgt_s = br_tgt_s;
    end else begin
      tgt_s = seq_pc_s;
    end
    if (jump_s) begin
      wdat_s = seq_pc_s;
    end else begin
      wdat_s = {XLEN{1'b0}};
    end
  end

  // Output register stage: load on accept, empty on a handshake alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_r <= 1'b0;
      wdat_r    <= {XLEN{1'b0}};
      wbck_en_r <= 1'b0;
      tgt_r     <= {XLEN{1'b0}};
      prdt_r    <= 1'b0;
      rslv_r    <= 1'b0;
      mispred_r <= 1'b0;
    end else if (accept_s) begin
      o_valid_r <= 1'b1;
      wdat_r    <= wdat_s;
      wbck_en_r <= jump_s;
      tgt_r     <= tgt_s;
      prdt_r    <= bjp_i_bprdt;
      rslv_r    <= rslv_s;
      mispred_r <= bjp_i_bprdt ^ rslv_s;
    end else if (handshake_s) begin
      o_valid_r <= 1'b0;
    end else begin
      o_valid_r <= o_valid_r;
    end
  end

  assign bjp_o_valid     = o_valid_r;
  assign bjp_o_wbck_wdat = wdat_r;
  assign bjp_o_wbck_en   = wbck_en_r;
  assign bjp_o_tgt_pc    = tgt_r;
  assign bjp_o_cmt_prdt  = prdt_r;
  assign bjp_o_cmt_rslv  = rslv_r;
  assign bjp_o_mispred   = mispred_r;

`ifdef E203_BJP_MISPRED_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Saturating misprediction counter; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (bjp_cnt_clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (handshake_s && mispred_r && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bjp_mispred_cnt = cnt_r;
`else
  logic cnt_clr_unused_s;

  assign cnt_clr_unused_s = bjp_cnt_clr;
  assign bjp_mispred_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_e203_exu_bjp_pipe.sv
// ---------------------------------------------------------------------------
// tb_e203_exu_bjp_pipe
//
// Directed bench for e203_exu_bjp_pipe (XLEN=32, CNT_W=2). Each step drives
// one request, advances one clock and compares outputs with hand-computed
// values. Counter expectations follow E203_BJP_MISPRED_CNT_EN: saturating at
// 3 when defined, always 0 otherwise.
// ---------------------------------------------------------------------------
module tb_e203_exu_bjp_pipe;

  localparam logic [2:0] BEQ  = 3'd0;
  localparam logic [2:0] BNE  = 3'd1;
  localparam logic [2:0] BLT  = 3'd2;
  localparam logic [2:0] BGE  = 3'd3;
  localparam logic [2:0] BLTU = 3'd4;
  localparam logic [2:0] BGEU = 3'd5;
  localparam logic [2:0] JAL  = 3'd6;
  localparam logic [2:0] JALR = 3'd7;

  logic        clk;
  logic        rst_n;
  logic        bjp_i_valid;
  logic        bjp_i_ready;
  logic [31:0] bjp_i_rs1;
  logic [31:0] bjp_i_rs2;
  logic [31:0] bjp_i_imm;
  logic [31:0] bjp_i_pc;
  logic [2:0]  bjp_i_op;
  logic        bjp_i_rv32;
  logic        bjp_i_bprdt;
  logic        bjp_o_valid;
  logic        bjp_o_ready;
  logic [31:0] bjp_o_wbck_wdat;
  logic        bjp_o_wbck_en;
  logic [31:0] bjp_o_tgt_pc;
  logic        bjp_o_cmt_prdt;
  logic        bjp_o_cmt_rslv;
  logic        bjp_o_mispred;
  logic        bjp_cnt_clr;
  logic [1:0]  bjp_mispred_cnt;

  int checks   = 0;
  int failures = 0;

  e203_exu_bjp_pipe #(.XLEN(32), .CNT_W(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bjp_i_valid     (bjp_i_valid),
    .bjp_i_ready     (bjp_i_ready),
    .bjp_i_rs1       (bjp_i_rs1),
    .bjp_i_rs2       (bjp_i_rs2),
    .bjp_i_imm       (bjp_i_imm),
    .bjp_i_pc        (bjp_i_pc),
    .bjp_i_op        (bjp_i_op),
    .bjp_i_rv32      (bjp_i_rv32),
    .bjp_i_bprdt     (bjp_i_bprdt),
    .bjp_o_valid     (bjp_o_valid),
    .bjp_o_ready     (bjp_o_ready),
    .bjp_o_wbck_wdat (bjp_o_wbck_wdat),
    .bjp_o_wbck_en   (bjp_o_wbck_en),
    .bjp_o_tgt_pc    (bjp_o_tgt_pc),
    .bjp_o_cmt_prdt  (bjp_o_cmt_prdt),
    .bjp_o_cmt_rslv  (bjp_o_cmt_rslv),
    .bjp_o_mispred   (bjp_o_mispred),
    .bjp_cnt_clr     (bjp_cnt_clr),
    .bjp_mispred_cnt (bjp_mispred_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected counter value after n mispredicting handshakes since last clear.
  function automatic logic [63:0] cexp(input int n);
`ifdef E203_BJP_MISPRED_CNT_EN
    return (n > 3) ? 64'd3 : 64'(n);
`else
    return (n >= 0) ? 64'd0 : 64'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [2:0] op, input logic [31:0] rs1,
                     input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                     input logic rv32, input logic prdt);
    bjp_i_valid = v;
    bjp_i_op    = op;
    bjp_i_rs1   = rs1;
    bjp_i_rs2   = rs2;
    bjp_i_imm   = imm;
    bjp_i_pc    = pc;
    bjp_i_rv32  = rv32;
    bjp_i_bprdt = prdt;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] tgt, input logic [31:0] wdat,
                         input logic en, input logic rslv, input logic prdt, input logic mis);
    chk({tag, ".valid"},   64'(bjp_o_valid),     64'd1);
    chk({tag, ".tgt"},     64'(bjp_o_tgt_pc),    64'(tgt));
    chk({tag, ".wdat"},    64'(bjp_o_wbck_wdat), 64'(wdat));
    chk({tag, ".wbck_en"}, 64'(bjp_o_wbck_en),   64'(en));
    chk({tag, ".rslv"},    64'(bjp_o_cmt_rslv),  64'(rslv));
    chk({tag, ".prdt"},    64'(bjp_o_cmt_prdt),  64'(prdt));
    chk({tag, ".mispred"}, 64'(bjp_o_mispred),   64'(mis));
  endtask

  initial begin
    rst_n       = 1'b1;
    bjp_o_ready = 1'b0;
    bjp_cnt_clr = 1'b0;
    req(1'b0, BEQ, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst.valid",   64'(bjp_o_valid),     64'd0);
    chk("rst.tgt",     64'(bjp_o_tgt_pc),    64'd0);
    chk("rst.wdat",    64'(bjp_o_wbck_wdat), 64'd0);
    chk("rst.wbck_en", 64'(bjp_o_wbck_en),   64'd0);
    chk("rst.rslv",    64'(bjp_o_cmt_rslv),  64'd0);
    chk("rst.prdt",    64'(bjp_o_cmt_prdt),  64'd0);
    chk("rst.mispred", 64'(bjp_o_mispred),   64'd0);
    chk("rst.cnt",     64'(bjp_mispred_cnt), 64'd0);
    chk("rst.i_ready", 64'(bjp_i_ready),     64'd1);
    #20;

    // Release reset mid-cycle; the very next edge accepts the BLT.
    rst_n = 1'b1;
    req(1'b1, BLT, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h100, 1'b1, 1'b0);
    tick();
    chk_out("blt", 32'h120, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("blt.i_ready_full", 64'(bjp_i_ready), 64'd0);

    // Consumer ready: BLT leaves while BLTU enters on the same edge.
    req(1'b1, BLTU, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h100, 1'b0, 1'b0);
    bjp_o_ready = 1'b1;
    #1;
    chk("i_ready_comb", 64'(bjp_i_ready), 64'd1);
    tick();
    chk_out("bltu", 32'h102, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cnt_after_blt", 64'(bjp_mispred_cnt), cexp(1));

    req(1'b1, JALR, 32'h1003, 32'h0, 32'h0, 32'h200, 1'b1, 1'b1);
    tick();
    chk_out("jalr", 32'h1002, 32'h204, 1'b1, 1'b1, 1'b1, 1'b0);

    req(1'b1, JAL, 32'h0, 32'h0, 32'h40, 32'h300, 1'b0, 1'b0);
    tick();
    chk_out("jal", 32'h340, 32'h302, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("cnt_after_jalr", 64'(bjp_mispred_cnt), cexp(1));

    // Target sum wraps past all-ones.
    req(1'b1, BEQ, 32'h5, 32'h5, 32'h20, 32'hFFFF_FFF0, 1'b1, 1'b1);
    tick();
    chk_out("beq_wrap", 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("cnt_after_jal", 64'(bjp_mispred_cnt), cexp(2));

    // Not-taken fall-through wraps to 0.
    req(1'b1, BNE, 32'h5, 32'h5, 32'h20, 32'hFFFF_FFFC, 1'b1, 1'b1);
    tick();
    chk_out("bne_nt", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    // BGE taken on equality, negative offset.
    req(1'b1, BGE, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF0, 32'h400, 1'b1, 1'b0);
    tick();
    chk_out("bge_eq", 32'h3F0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("cnt_after_bne", 64'(bjp_mispred_cnt), cexp(3));

    // Unsigned: 1 >= 0xFFFFFFFF is false.
    req(1'b1, BGEU, 32'h1, 32'hFFFF_FFFF, 32'h80, 32'h500, 1'b0, 1'b0);
    tick();
    chk_out("bgeu_nt", 32'h502, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cnt_after_bge", 64'(bjp_mispred_cnt), cexp(4));

    // Signed: -1 >= 1 is false.
    req(1'b1, BGE, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h600, 1'b1, 1'b0);
    tick();
    chk_out("bge_nt", 32'h604, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Handshake without accept empties the stage.
    req(1'b0, BEQ, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("drain.valid", 64'(bjp_o_valid), 64'd0);

    bjp_cnt_clr = 1'b1;
    tick();
    bjp_cnt_clr = 1'b0;
    chk("clr.cnt", 64'(bjp_mispred_cnt), 64'd0);

    // Six mispredicting JALs back to back; count saturates.
    for (int k = 0; k < 6; k++) begin
      req(1'b1, JAL, 32'h0, 32'h0, 32'h8, 32'h700, 1'b1, 1'b0);
      tick();
      chk($sformatf("sat.cnt%0d", k), 64'(bjp_mispred_cnt), cexp(k));
    end
    // Clear coincides with the sixth mispredict handshake; clear wins.
    req(1'b0, BEQ, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    bjp_cnt_clr = 1'b1;
    tick();
    bjp_cnt_clr = 1'b0;
    chk("clr_win.cnt",   64'(bjp_mispred_cnt), 64'd0);
    chk("clr_win.valid", 64'(bjp_o_valid),     64'd0);

    // Four back-to-back requests with a three-cycle consumer stall.
    bjp_o_ready = 1'b0;
    req(1'b1, JAL, 32'h0, 32'h0, 32'h10, 32'h1000, 1'b1, 1'b1);
    tick();
    req(1'b1, JAL, 32'h0, 32'h0, 32'h20, 32'h1000, 1'b1, 1'b1);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("stall%0d.i_ready", s), 64'(bjp_i_ready),  64'd0);
      chk($sformatf("stall%0d.tgt", s),     64'(bjp_o_tgt_pc), 64'h1010);
      chk($sformatf("stall%0d.valid", s),   64'(bjp_o_valid),  64'd1);
      tick();
    end
    chk("stall_end.tgt", 64'(bjp_o_tgt_pc), 64'h1010);
    bjp_o_ready = 1'b1;
    tick();
    chk_out("b2b_b", 32'h1020, 32'h1004, 1'b1, 1'b1, 1'b1, 1'b0);
    req(1'b1, JAL, 32'h0, 32'h0, 32'h30, 32'h1000, 1'b1, 1'b1);
    tick();
    chk_out("b2b_c", 32'h1030, 32'h1004, 1'b1, 1'b1, 1'b1, 1'b0);
    req(1'b1, JAL, 32'h0, 32'h0, 32'h40, 32'h1000, 1'b1, 1'b1);
    tick();
    chk_out("b2b_d", 32'h1040, 32'h1004, 1'b1, 1'b1, 1'b1, 1'b0);
    req(1'b0, BEQ, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("b2b_end.valid", 64'(bjp_o_valid), 64'd0);

    // Reset pulse while full and stalled discards the held entry.
    bjp_o_ready = 1'b0;
    req(1'b1, JAL, 32'h0, 32'h0, 32'h50, 32'h1000, 1'b1, 1'b0);
    tick();
    chk_out("held", 32'h1050, 32'h1004, 1'b1, 1'b1, 1'b0, 1'b1);
    req(1'b0, BEQ, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.valid",   64'(bjp_o_valid),     64'd0);
    chk("midrst.tgt",     64'(bjp_o_tgt_pc),    64'd0);
    chk("midrst.wdat",    64'(bjp_o_wbck_wdat), 64'd0);
    chk("midrst.mispred", 64'(bjp_o_mispred),   64'd0);
    chk("midrst.cnt",     64'(bjp_mispred_cnt), 64'd0);
    #2 rst_n = 1'b1;
    bjp_o_ready = 1'b1;
    tick();
    chk("post_rst0.valid", 64'(bjp_o_valid), 64'd0);
    tick();
    chk("post_rst1.valid", 64'(bjp_o_valid),     64'd0);
    chk("post_rst1.cnt",   64'(bjp_mispred_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
